// File: rtl/score_keeper_pkg.sv
// Shared types, winner codes and seven-segment glyphs for the BASPONG score keeper.
package score_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] BLANK   = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = GLYPH_0;
            4'd1:    s = GLYPH_1;
            4'd2:    s = GLYPH_2;
            4'd3:    s = GLYPH_3;
            4'd4:    s = GLYPH_4;
            4'd5:    s = GLYPH_5;
            4'd6:    s = GLYPH_6;
            4'd7:    s = GLYPH_7;
            4'd8:    s = GLYPH_8;
            4'd9:    s = GLYPH_9;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Two-digit BCD increment; ones 9 wraps to 0 and carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Score pulses and restart in, match state and display drive out; master is the pulse source.
interface score_keeper_if;
    logic       score1;
    logic       score2;
    logic       new_game;
    logic       game_over;
    logic [1:0] winner;
    logic [7:0] p1_bcd;
    logic [7:0] p2_bcd;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output score1, score2, new_game,
        input  game_over, winner, p1_bcd, p2_bcd, an, seg, dp
    );

    modport slave (
        input  score1, score2, new_game,
        output game_over, winner, p1_bcd, p2_bcd, an, seg, dp
    );
endinterface

// File: rtl/score_keeper_seg7_scan.sv
// Multiplexes four BCD digits onto the 4-digit display; outputs trail the digit index by one register.
// A set mask bit keeps that digit's anode high; a set blank flag shows no segments.
module seg7_scan
    import score_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0][3:0] digits_i,
    input  logic [3:0]      blank_i,
    input  logic [3:0]      mask_i,
    output logic [3:0]      an_o,
    output logic [6:0]      seg_o,
    output logic            dp_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end

        an_d = ~(4'b0001 << idx_q);
        if (mask_i[idx_q]) an_d = 4'b1111;
        seg_d = blank_i[idx_q] ? BLANK : bcd_to_seg(digits_i[idx_q]);
        // Decimal point after player 1's ones digit separates the two scores.
        dp_d  = (idx_q != 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= GLYPH_0;
            dp_q       <= 1'b1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: rtl/score_keeper.sv
// BASPONG match score: edge-detected score pulses feed two BCD counters, win detection freezes the match.
// Counters/winner update one cycle after a pulse; display lags by up to 4*SCAN_DIV+1. SCORE_BLINK_EN blinks the winner.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE = 7,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic         clk,
    input  logic         reset,
    score_keeper_if.slave bus
);

    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    logic       score1_q, score2_q, new_game_q;
    logic       s1_ev, s2_ev, ng_ev;
    state_e     state_q, state_d;
    logic [7:0] p1_q, p1_d, p2_q, p2_d;
    logic [7:0] p1_inc, p2_inc;
    logic       win1, win2;
    logic [1:0] winner_q, winner_d;
    logic       game_over_q, game_over_d;
    logic [3:0] blink_mask;

    // Inputs share our clock with the animation block, so no synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score1_q   <= 1'b0;
            score2_q   <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            score1_q   <= bus.score1;
            score2_q   <= bus.score2;
            new_game_q <= bus.new_game;
        end
    end

    assign s1_ev  = bus.score1 & ~score1_q;
    assign s2_ev  = bus.score2 & ~score2_q;
    assign ng_ev  = bus.new_game & ~new_game_q;
    assign p1_inc = bcd_inc(p1_q);
    assign p2_inc = bcd_inc(p2_q);
    assign win1   = s1_ev && (p1_inc == WIN_BCD);
    assign win2   = s2_ev && (p2_inc == WIN_BCD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= PLAY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY:    if (ng_ev) state_d = PLAY;
                     else if (win1 || win2) state_d = OVER;
            OVER:    if (ng_ev) state_d = PLAY;
            default: state_d = PLAY;
        endcase
    end

    // Restart takes priority over any score edge in the same cycle.
    always_comb begin
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        if (ng_ev) begin
            p1_d     = 8'h00;
            p2_d     = 8'h00;
            winner_d = WIN_NONE;
        end else if (state_q == PLAY) begin
            if (s1_ev) p1_d = p1_inc;
            if (s2_ev) p2_d = p2_inc;
            if (win1 || win2) winner_d = {win2, win1};
        end
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    // Toggle is held at visible outside OVER so every match end starts lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_off_d = blink_off_q;
        if (!game_over_q) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blink_mask = blink_off_q ? {winner_q[0], winner_q[0], winner_q[1], winner_q[1]} : 4'b0000;
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign blink_mask       = 4'b0000;
`endif

    logic [3:0] an_w;
    logic [6:0] seg_w;
    logic       dp_w;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .digits_i ({p1_q, p2_q}),
        .blank_i  ({p1_q[7:4] == 4'd0, 1'b0, p2_q[7:4] == 4'd0, 1'b0}),
        .mask_i   (blink_mask),
        .an_o     (an_w),
        .seg_o    (seg_w),
        .dp_o     (dp_w)
    );

    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
    assign bus.p1_bcd    = p1_q;
    assign bus.p2_bcd    = p2_q;
    assign bus.an        = an_w;
    assign bus.seg       = seg_w;
    assign bus.dp        = dp_w;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: one instance with WIN_SCORE=7, one with WIN_SCORE=12, short scan/blink periods.
`timescale 1ns/1ps
module tb_score_keeper;
    import score_pkg::*;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_keeper_if a_if();
    score_keeper_if b_if();

    score_keeper #(.WIN_SCORE(7), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut7 (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    score_keeper #(.WIN_SCORE(12), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut12 (
        .clk(clk), .reset(reset), .bus(b_if.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit on_b, input logic s1, input logic s2);
        if (on_b) begin b_if.score1 = s1; b_if.score2 = s2; end
        else      begin a_if.score1 = s1; a_if.score2 = s2; end
        tick();
        a_if.score1 = 1'b0; a_if.score2 = 1'b0;
        b_if.score1 = 1'b0; b_if.score2 = 1'b0;
        tick();
    endtask

    task automatic wait_an(input bit on_b, input logic [3:0] want, output bit found);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if ((on_b ? b_if.an : a_if.an) == want) found = 1'b1;
        end
    endtask

    task automatic wait_change(output int n);
        logic [3:0] prev;
        prev = a_if.an;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_if.an == prev && n < 4 * SCAN);
    endtask

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    initial begin
        bit found;
        int n;
        int dark;

        exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_seg = '{BLANK, GLYPH_0, BLANK, GLYPH_0};
        exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        a_if.score1 = 0; a_if.score2 = 0; a_if.new_game = 0;
        b_if.score1 = 0; b_if.score2 = 0; b_if.new_game = 0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_p1", a_if.p1_bcd, 8'h00);
        check("rst_p2", a_if.p2_bcd, 8'h00);
        check("rst_go", a_if.game_over, 1'b0);
        check("rst_winner", a_if.winner, WIN_NONE);
        check("rst_an", a_if.an, 4'b1110);
        check("rst_seg", a_if.seg, GLYPH_0);
        check("rst_dp", a_if.dp, 1'b1);

        // Digit scan with both scores at zero.
        for (int k = 0; k < 4; k++) begin
            wait_change(n);
            check($sformatf("scan_an%0d", k), a_if.an, exp_an[k]);
            check($sformatf("scan_seg%0d", k), a_if.seg, exp_seg[k]);
            check($sformatf("scan_dp%0d", k), a_if.dp, exp_dp[k]);
            if (k > 0) check($sformatf("scan_period%0d", k), n, SCAN);
        end

        // A held score2 level counts once.
        a_if.score2 = 1'b1;
        repeat (5) tick();
        a_if.score2 = 1'b0;
        tick();
        check("hold_p2", a_if.p2_bcd, 8'h01);

        for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1, 1'b0);
        check("p1_six", a_if.p1_bcd, 8'h06);
        check("go_before_win", a_if.game_over, 1'b0);
        a_if.score1 = 1'b1;
        tick();
        check("win_p1", a_if.p1_bcd, 8'h07);
        check("win_go", a_if.game_over, 1'b1);
        check("win_winner", a_if.winner, WIN_P1);
        a_if.score1 = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        check("over_p1_hold", a_if.p1_bcd, 8'h07);
        check("over_p2_hold", a_if.p2_bcd, 8'h01);
        check("over_winner_hold", a_if.winner, WIN_P1);

        a_if.new_game = 1'b1;
        tick();
        check("ng_p1", a_if.p1_bcd, 8'h00);
        check("ng_p2", a_if.p2_bcd, 8'h00);
        check("ng_go", a_if.game_over, 1'b0);
        check("ng_winner", a_if.winner, WIN_NONE);
        a_if.new_game = 1'b0;
        tick();

        // Restart in PLAY, colliding with a score edge that must be dropped.
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("play_p1_two", a_if.p1_bcd, 8'h02);
        a_if.new_game = 1'b1;
        a_if.score1   = 1'b1;
        tick();
        check("ng_vs_score_p1", a_if.p1_bcd, 8'h00);
        a_if.new_game = 1'b0;
        a_if.score1   = 1'b0;
        tick();

        // Tie: both reach the winning score on the same edge.
        for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1, 1'b1);
        check("tie_p1_six", a_if.p1_bcd, 8'h06);
        check("tie_p2_six", a_if.p2_bcd, 8'h06);
        a_if.score1 = 1'b1;
        a_if.score2 = 1'b1;
        tick();
        check("tie_winner", a_if.winner, WIN_TIE);
        check("tie_go", a_if.game_over, 1'b1);
        a_if.score1 = 1'b0;
        a_if.score2 = 1'b0;

        wait_an(1'b0, 4'b1011, found);
        check("tie_an_p1_ones", found, 1'b1);
        check("tie_seg_p1_ones", a_if.seg, GLYPH_7);

`ifdef SCORE_BLINK_EN
        wait_an(1'b0, 4'b1111, found);
        check("tie_blink_dark", found, 1'b1);
`else
        dark = 0;
        for (int i = 0; i < 4 * BLINK; i++) begin
            tick();
            if (a_if.an == 4'b1111) dark++;
        end
        check("tie_steady_display", dark, 0);
`endif

        // Asynchronous reset in OVER clears at once.
        reset = 1'b1;
        #1;
        check("areset_p1", a_if.p1_bcd, 8'h00);
        check("areset_go", a_if.game_over, 1'b0);
        check("areset_winner", a_if.winner, WIN_NONE);
        check("areset_an", a_if.an, 4'b1110);
        tick();
        reset = 1'b0;
        tick();

        // Ones-to-tens carry on the 12-point instance.
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b1, 1'b0);
        check("b_p1_nine", b_if.p1_bcd, 8'h09);
        pulse(1'b1, 1'b1, 1'b0);
        check("b_p1_ten", b_if.p1_bcd, 8'h10);
        check("b_go_ten", b_if.game_over, 1'b0);
        wait_an(1'b1, 4'b0111, found);
        check("b_an_tens", found, 1'b1);
        check("b_seg_tens", b_if.seg, GLYPH_1);
        wait_an(1'b1, 4'b1011, found);
        check("b_an_ones", found, 1'b1);
        check("b_seg_ones", b_if.seg, GLYPH_0);
        check("b_dp_ones", b_if.dp, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
